// File: rtl/rvga_mem_arbiter.sv
// rvga_mem_arbiter
// ----------------
// Merges NUM_PORTS pipeline memory requesters (fetch, data, DMA, debug...)
// onto a single external DDR-style port. The requester side and the memory
// side use the same read/write/resp handshake, so any requester port can
// replace a dedicated DDR port.
//
// Handshake (both sides): a requester raises read or write together with
// addr/wdata and holds all of them until it sees a one-cycle resp pulse.
// The resp cycle is the completion cycle, and read data is valid only in
// that cycle. A request still high after resp counts as a new request.
//
// Arbitration: round-robin by default. The search starts at pointer+1 and
// wraps, and the pointer then moves to the winner. Define
// RVGA_ARB_FIXED_PRIO_EN to get fixed priority instead: the lowest index
// wins, and no pointer is kept.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_addr/req_wdata    per-port packed slices [i*W +: W]
//   req_read/req_write    per-port request strobes (write wins if both)
//   req_rdata             mem_rdata broadcast, qualified by req_resp[i]
//   req_resp              one-hot completion pulse to the granted port
//   mem_*                 external port; strobes/addr/wdata are registered
//   grant_id              index of the port being served (debug)
//   busy                  FSM state: high while a transaction is outstanding
module rvga_mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_read,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             mem_write,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_resp,
  output logic [GW-1:0]                    grant_id,
  output logic                             busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state, next_state;
  logic [NUM_PORTS-1:0] req_any;
  logic                 win_found;
  logic [GW-1:0]        win_idx;

`ifndef RVGA_ARB_FIXED_PRIO_EN
  logic [GW-1:0]        rr_ptr;
`endif

  assign req_any = req_read | req_write;

  // Winner selection, purely combinational from the current requests.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef RVGA_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!win_found && req_any[k]) begin
        win_found = 1'b1;
        win_idx   = GW'(k);
      end
    end
`else
    // k runs 1..NUM_PORTS so the port just served is considered last.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!win_found && req_any[(int'(rr_ptr) + k) % NUM_PORTS]) begin
        win_found = 1'b1;
        win_idx   = GW'((int'(rr_ptr) + k) % NUM_PORTS);
      end
    end
`endif
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_found) next_state = BUSY;
      BUSY:    if (mem_resp)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The granted request is captured here, so later changes on req_* do
  // not reach the memory side while BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      grant_id  <= '0;
`ifndef RVGA_ARB_FIXED_PRIO_EN
      rr_ptr    <= GW'(NUM_PORTS - 1);
`endif
    end else if (state == IDLE && win_found) begin
      mem_addr  <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata <= req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      // Write takes precedence when a port raises both strobes.
      mem_write <= req_write[win_idx];
      mem_read  <= req_read[win_idx] & ~req_write[win_idx];
      grant_id  <= win_idx;
`ifndef RVGA_ARB_FIXED_PRIO_EN
      rr_ptr    <= win_idx;
`endif
    end else if (state == BUSY && mem_resp) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  // Completion is passed straight through, with no added latency.
  always_comb begin
    req_resp = '0;
    if (state == BUSY && mem_resp) req_resp[grant_id] = 1'b1;
  end

  assign req_rdata = mem_rdata;
  assign busy      = (state == BUSY);

  // A port that raises read and write together is a requester bug.
  a_no_rw_both: assert property (@(posedge clk) disable iff (!rst_n)
    !(|(req_read & req_write)));

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
module tb_rvga_mem_arbiter;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*AW-1:0]  req_addr;
  logic [NP-1:0]     req_read;
  logic [NP-1:0]     req_write;
  logic [NP*DW-1:0]  req_wdata;
  logic [DW-1:0]     req_rdata;
  logic [NP-1:0]     req_resp;
  logic [AW-1:0]     mem_addr;
  logic              mem_read;
  logic [DW-1:0]     mem_rdata;
  logic              mem_write;
  logic [DW-1:0]     mem_wdata;
  logic              mem_resp;
  logic [0:0]        grant_id;
  logic              busy;

  int checks = 0;
  int failures = 0;

  // Expected grant sequence with both ports requesting continuously.
  // The pointer is at port 1 when this test starts.
  logic [0:0] exp_grant_q[$];

  rvga_mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_addr  (req_addr),
    .req_read  (req_read),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_rdata (req_rdata),
    .req_resp  (req_resp),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_resp  (mem_resp),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_addr  = '0;
    req_read  = '0;
    req_write = '0;
    req_wdata = '0;
    mem_rdata = '0;
    mem_resp  = 1'b0;

    // Values while held in reset.
    #3;
    check("rst_mem_read",  {63'd0, mem_read}, 64'd0);
    check("rst_mem_write", {63'd0, mem_write}, 64'd0);
    check("rst_busy",      {63'd0, busy}, 64'd0);
    check("rst_mem_addr",  {32'd0, mem_addr}, 64'd0);
    check("rst_grant",     {63'd0, grant_id}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Single read, port 0, memory responds in the third BUSY cycle.
    req_read        = 2'b01;
    req_addr[31:0]  = 32'h100;
    tick();
    #1;
    check("rd_mem_read",  {63'd0, mem_read}, 64'd1);
    check("rd_mem_write", {63'd0, mem_write}, 64'd0);
    check("rd_mem_addr",  {32'd0, mem_addr}, 64'h100);
    check("rd_grant",     {63'd0, grant_id}, 64'd0);
    check("rd_no_resp_early", {62'd0, req_resp}, 64'd0);
    tick(); tick();
    mem_resp  = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    check("rd_resp",  {62'd0, req_resp}, 64'b01);
    check("rd_rdata", {32'd0, req_rdata}, 64'hDEADBEEF);
    tick();
    mem_resp = 1'b0;
    req_read = 2'b00;
    #1;
    check("rd_done_busy",     {63'd0, busy}, 64'd0);
    check("rd_done_mem_read", {63'd0, mem_read}, 64'd0);
    check("rd_done_resp",     {62'd0, req_resp}, 64'd0);

    // Write from port 1.
    req_write        = 2'b10;
    req_addr[63:32]  = 32'h200;
    req_wdata[63:32] = 32'h12345678;
    tick();
    #1;
    check("wr_mem_write", {63'd0, mem_write}, 64'd1);
    check("wr_mem_read",  {63'd0, mem_read}, 64'd0);
    check("wr_mem_addr",  {32'd0, mem_addr}, 64'h200);
    check("wr_mem_wdata", {32'd0, mem_wdata}, 64'h12345678);
    check("wr_grant",     {63'd0, grant_id}, 64'd1);
    tick();
    check("wr_grant_hold", {63'd0, grant_id}, 64'd1);
    mem_resp = 1'b1;
    #1;
    check("wr_resp", {62'd0, req_resp}, 64'b10);
    tick();
    mem_resp  = 1'b0;
    req_write = 2'b00;

    // mem_resp in IDLE is ignored.
    mem_resp = 1'b1;
    #1;
    check("idle_resp_ignored", {62'd0, req_resp}, 64'd0);
    tick();
    mem_resp = 1'b0;
    #1;
    check("idle_stays", {63'd0, busy}, 64'd0);

    // Both ports request continuously.
`ifdef RVGA_ARB_FIXED_PRIO_EN
    exp_grant_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_grant_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    req_read        = 2'b11;
    req_addr[31:0]  = 32'hA00;
    req_addr[63:32] = 32'hB00;
    while (exp_grant_q.size() > 0) begin
      logic [0:0] g;
      g = exp_grant_q.pop_front();
      tick();
      #1;
      check("rr_busy",  {63'd0, busy}, 64'd1);
      check("rr_grant", {63'd0, grant_id}, {63'd0, g});
      check("rr_addr",  {32'd0, mem_addr}, (g == 1'b0) ? 64'hA00 : 64'hB00);
      tick();
      mem_resp = 1'b1;
      #1;
      check("rr_resp", {62'd0, req_resp}, (g == 1'b0) ? 64'b01 : 64'b10);
      tick();
      mem_resp = 1'b0;
      #1;
      check("rr_gap_idle", {63'd0, busy}, 64'd0);
    end
    req_read = 2'b00;
    tick();

    // Captured request stays put while port 0's inputs change mid-BUSY.
    req_read        = 2'b01;
    req_addr[31:0]  = 32'h40;
    tick();
    #1;
    check("ls_grant", {63'd0, grant_id}, 64'd0);
    check("ls_addr",  {32'd0, mem_addr}, 64'h40);
    req_addr[31:0]  = 32'h80;
    req_addr[63:32] = 32'h300;
    req_read        = 2'b11;
    tick();
    check("ls_addr_hold", {32'd0, mem_addr}, 64'h40);
    tick();
    mem_resp = 1'b1;
    #1;
    check("ls_addr_at_resp", {32'd0, mem_addr}, 64'h40);
    check("ls_resp", {62'd0, req_resp}, 64'b01);
    tick();
    mem_resp = 1'b0;
    req_read = 2'b10;
    #1;
    check("ls_gap", {63'd0, busy}, 64'd0);
    tick();
    #1;
    check("ls_p1_grant", {63'd0, grant_id}, 64'd1);
    check("ls_p1_addr",  {32'd0, mem_addr}, 64'h300);
    mem_resp = 1'b1;
    #1;
    check("ls_p1_resp", {62'd0, req_resp}, 64'b10);
    tick();
    mem_resp = 1'b0;
    req_read = 2'b00;
    tick();

    // Asynchronous reset while BUSY for port 0. Just before it, the pointer
    // sits at port 0, so a kept pointer would pick port 1 next.
    req_read        = 2'b01;
    req_addr[31:0]  = 32'h500;
    tick();
    #1;
    check("ar_busy_before", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_mem_read", {63'd0, mem_read}, 64'd0);
    check("ar_busy",     {63'd0, busy}, 64'd0);
    check("ar_mem_addr", {32'd0, mem_addr}, 64'd0);
    mem_resp = 1'b1;
    #1;
    check("ar_no_resp", {62'd0, req_resp}, 64'd0);
    tick();
    mem_resp = 1'b0;
    rst_n    = 1'b1;
    req_read = 2'b11;
    tick();
    #1;
    check("ar_first_grant", {63'd0, grant_id}, 64'd0);
    check("ar_first_addr",  {32'd0, mem_addr}, 64'h500);
    mem_resp = 1'b1;
    #1;
    check("ar_resp", {62'd0, req_resp}, 64'b01);
    tick();
    mem_resp = 1'b0;
    req_read = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
